// File: rtl/dcache_if.sv
// dcache_if: request/response port of the L1 data cache toward MEM, plus its
// line-read and word-write ports toward the memory side.
//   slave  : the cache (takes dc_* requests, drives mem_* requests)
//   master : the environment (MEM stage requester and the memory model)
interface dcache_if #(
   parameter int unsigned ADDR_WIDTH = 64
);
   // MEM-stage request / response
   logic                  invalidate_all;
   logic                  dc_en;
   logic [ADDR_WIDTH-1:0] dc_in_addr;
   logic                  dc_write_en;
   logic [63:0]           dc_in_wdata;
   logic [1:0]            dc_in_wlen;
   logic [63:0]           dc_out_rdata;
   logic                  dc_out_rvalid;
   logic                  dc_out_write_done;

   // Line-read port
   logic                  mem_rd_valid;
   logic                  mem_rd_ready;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic                  mem_rd_beat_valid;
   logic [63:0]           mem_rd_beat;

   // Word-write port
   logic                  mem_wr_valid;
   logic                  mem_wr_ready;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic [63:0]           mem_wr_data;
   logic [7:0]            mem_wr_strb;
   logic                  mem_wr_done;

   modport slave (
      input  invalidate_all, dc_en, dc_in_addr, dc_write_en, dc_in_wdata, dc_in_wlen,
      output dc_out_rdata, dc_out_rvalid, dc_out_write_done,
      output mem_rd_valid, mem_rd_addr,
      input  mem_rd_ready, mem_rd_beat_valid, mem_rd_beat,
      output mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb,
      input  mem_wr_ready, mem_wr_done
   );

   modport master (
      output invalidate_all, dc_en, dc_in_addr, dc_write_en, dc_in_wdata, dc_in_wlen,
      input  dc_out_rdata, dc_out_rvalid, dc_out_write_done,
      input  mem_rd_valid, mem_rd_addr,
      output mem_rd_ready, mem_rd_beat_valid, mem_rd_beat,
      input  mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb,
      output mem_wr_ready, mem_wr_done
   );
endinterface

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate L1 data cache.
// One outstanding request; load hits answer the cycle after the request is
// taken, misses refill a 64-byte line as 8 ascending beats, stores always
// go to memory (merged into the line first when they hit).
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : dcache_if.slave (MEM request/response, line-read, word-write)
module dcache_dm #(
   parameter int unsigned SETS       = 64,
   parameter int unsigned ADDR_WIDTH = 64
) (
   input  logic    clk,
   input  logic    reset,
   dcache_if.slave bus
);

   localparam int unsigned SET_BITS = $clog2(SETS);
   localparam int unsigned TAG_LSB  = 6 + SET_BITS;
   localparam int unsigned TAG_W    = ADDR_WIDTH - TAG_LSB;
   localparam int unsigned WORDS    = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_RD_REQ,
      S_REFILL,
      S_WR_REQ,
      S_WR_WAIT
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  write_en;
      logic [63:0]           wdata;
      logic [1:0]            wlen;
   } req_t;

   state_t               r_state;
   state_t               w_next_state;
   req_t                 r_req;
   logic [SETS-1:0]      r_valid;
   logic [TAG_W-1:0]     r_tag  [SETS];
   logic [63:0]          r_data [SETS][WORDS];
   logic [2:0]           r_cnt;

   logic [SET_BITS-1:0]  w_set;
   logic [2:0]           w_word;
   logic [2:0]           w_off;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_hit;
   logic [7:0]           w_len_mask;
   logic [7:0]           w_strb;
   logic [63:0]          w_wdata_sh;
   logic                 w_cross;

   logic [63:0]          w_rdata;
   logic                 w_rvalid;
   logic                 w_write_done;
   logic                 w_rd_valid;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic                 w_wr_valid;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [63:0]          w_wr_data;
   logic [7:0]           w_wr_strb;

   // Address decode of the latched request
   assign w_set      = r_req.addr[TAG_LSB-1:6];
   assign w_word     = r_req.addr[5:3];
   assign w_off      = r_req.addr[2:0];
   assign w_tag      = r_req.addr[ADDR_WIDTH-1:TAG_LSB];
   assign w_hit      = r_valid[w_set] && (r_tag[w_set] == w_tag);

   // Byte-lane alignment of store data and enables
   always_comb begin
      w_len_mask = 8'h00;
      case (r_req.wlen)
         2'd0:    w_len_mask = 8'h01;
         2'd1:    w_len_mask = 8'h03;
         2'd2:    w_len_mask = 8'h0F;
         default: w_len_mask = 8'hFF;
      endcase
   end
   assign w_strb     = 8'(w_len_mask << w_off);
   assign w_wdata_sh = r_req.wdata << {w_off, 3'b000};

   // Incoming access must stay within one 8-byte word
   assign w_cross = ({1'b0, bus.dc_in_addr[2:0]} + (4'd1 << bus.dc_in_wlen)) > 4'd8;

   a_no_word_cross: assert property (@(posedge clk) disable iff (reset)
      (r_state == S_IDLE && bus.dc_en) |-> !w_cross)
      else $error("dcache_dm: access crosses an 8-byte boundary");

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic; started refills and writes run to completion even
   // if the requester has gone away
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.dc_en) w_next_state = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (!bus.dc_en)             w_next_state = S_IDLE;
            else if (r_req.write_en)    w_next_state = S_WR_REQ;
            else if (w_hit)             w_next_state = S_IDLE;
            else                        w_next_state = S_RD_REQ;
         end
         S_RD_REQ: begin
            if (bus.mem_rd_ready) w_next_state = S_REFILL;
         end
         S_REFILL: begin
            if (bus.mem_rd_beat_valid && r_cnt == 3'd7) w_next_state = S_LOOKUP;
         end
         S_WR_REQ: begin
            if (bus.mem_wr_ready) w_next_state = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (bus.mem_wr_done) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs; response pulses are suppressed while dc_en is low
   always_comb begin
      w_rdata      = '0;
      w_rvalid     = 1'b0;
      w_write_done = 1'b0;
      w_rd_valid   = 1'b0;
      w_rd_addr    = '0;
      w_wr_valid   = 1'b0;
      w_wr_addr    = '0;
      w_wr_data    = '0;
      w_wr_strb    = '0;
      case (r_state)
         S_LOOKUP: begin
            if (bus.dc_en && !r_req.write_en && w_hit) begin
               w_rvalid = 1'b1;
               w_rdata  = r_data[w_set][w_word];
            end
         end
         S_RD_REQ: begin
            w_rd_valid = 1'b1;
            w_rd_addr  = {r_req.addr[ADDR_WIDTH-1:6], 6'b0};
         end
         S_WR_REQ: begin
            w_wr_valid = 1'b1;
            w_wr_addr  = {r_req.addr[ADDR_WIDTH-1:3], 3'b0};
            w_wr_data  = w_wdata_sh;
            w_wr_strb  = w_strb;
         end
         S_WR_WAIT: begin
            w_write_done = bus.mem_wr_done && bus.dc_en;
         end
         default: ;
      endcase
   end

   assign bus.dc_out_rdata      = w_rdata;
   assign bus.dc_out_rvalid     = w_rvalid;
   assign bus.dc_out_write_done = w_write_done;
   assign bus.mem_rd_valid      = w_rd_valid;
   assign bus.mem_rd_addr       = w_rd_addr;
   assign bus.mem_wr_valid      = w_wr_valid;
   assign bus.mem_wr_addr       = w_wr_addr;
   assign bus.mem_wr_data       = w_wr_data;
   assign bus.mem_wr_strb       = w_wr_strb;

   // Control state: request latch, valid bits, beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req   <= '0;
         r_valid <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.dc_en) begin
                  r_req <= '{addr:     bus.dc_in_addr,
                             write_en: bus.dc_write_en,
                             wdata:    bus.dc_in_wdata,
                             wlen:     bus.dc_in_wlen};
               end else if (bus.invalidate_all) begin
                  r_valid <= '0;
               end
            end
            S_RD_REQ: begin
               if (bus.mem_rd_ready) r_cnt <= '0;
            end
            S_REFILL: begin
               if (bus.mem_rd_beat_valid) begin
                  r_cnt <= r_cnt + 3'd1;
                  if (r_cnt == 3'd7) r_valid[w_set] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data storage (contents are qualified by r_valid, so no reset)
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == S_LOOKUP && bus.dc_en && r_req.write_en && w_hit) begin
            for (int b = 0; b < 8; b++) begin
               if (w_strb[b]) r_data[w_set][w_word][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
         end
         if (r_state == S_REFILL && bus.mem_rd_beat_valid) begin
            r_data[w_set][r_cnt] <= bus.mem_rd_beat;
            if (r_cnt == 3'd7) r_tag[w_set] <= w_tag;
         end
      end
   end

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed self-checking bench for dcache_dm. Plays both the
// MEM requester and a memory that returns beat i of a line as base+i.
module tb_dcache_dm;

   localparam int unsigned SETS = 64;
   localparam int unsigned AW   = 64;

   logic clk;
   logic reset;

   dcache_if #(.ADDR_WIDTH(AW)) bus ();

   dcache_dm #(.SETS(SETS), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   int          t_cycles;
   int          t_nrd;
   int          t_nwr;
   int          t_npulse;
   logic [63:0] t_rdata;
   logic [63:0] t_rd_addr;
   logic [63:0] t_wr_addr;
   logic [63:0] t_wr_data;
   logic [7:0]  t_wr_strb;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic inv);
      for (int i = 0; i < n; i++) begin
         bus.dc_en          = 1'b0;
         bus.invalidate_all = inv;
         tick();
      end
      bus.invalidate_all = 1'b0;
   endtask

   // One request, cycle k=0 being the first cycle dc_en is high. Memory
   // grants immediately, streams 8 beats after the read handshake and acks
   // a write one cycle after its handshake. drop_beat >= 0 lowers dc_en on
   // the cycle that beat is presented and keeps it low.
   task automatic run_req(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                          input logic [1:0] wlen, input logic [63:0] beat_base,
                          input logic inv, input int drop_beat);
      int beat;
      bit dropped;
      bit wr_pend;
      bit stop;
      beat = -1; dropped = 0; wr_pend = 0; stop = 0;
      t_cycles = -1; t_nrd = 0; t_nwr = 0; t_npulse = 0;
      t_rdata = '0; t_rd_addr = '0; t_wr_addr = '0; t_wr_data = '0; t_wr_strb = '0;
      bus.dc_in_addr  = addr;
      bus.dc_write_en = we;
      bus.dc_in_wdata = wdata;
      bus.dc_in_wlen  = wlen;
      for (int k = 0; k < 40 && !stop; k++) begin
         bus.invalidate_all    = inv;
         bus.mem_rd_beat_valid = (beat >= 0 && beat < 8);
         bus.mem_rd_beat       = bus.mem_rd_beat_valid ? beat_base + 64'(beat) : 64'd0;
         if (bus.mem_rd_beat_valid && beat == drop_beat) dropped = 1;
         bus.dc_en       = !dropped;
         bus.mem_wr_done = wr_pend;
         wr_pend = 0;
         #1;
         if (bus.mem_rd_valid && bus.mem_rd_ready) begin
            t_nrd++;
            t_rd_addr = bus.mem_rd_addr;
            beat = 0;
         end else if (beat >= 0 && beat < 8) begin
            beat++;
         end
         if (bus.mem_wr_valid && bus.mem_wr_ready) begin
            t_nwr++;
            t_wr_addr = bus.mem_wr_addr;
            t_wr_data = bus.mem_wr_data;
            t_wr_strb = bus.mem_wr_strb;
            wr_pend   = 1;
         end
         if (bus.dc_out_rvalid) begin
            t_npulse++;
            t_rdata  = bus.dc_out_rdata;
            t_cycles = k;
         end
         if (bus.dc_out_write_done) begin
            t_npulse++;
            t_cycles = k;
         end
         if (t_npulse > 0 && !dropped) stop = 1;
         if (dropped && k >= 25) stop = 1;
         tick();
      end
      bus.dc_en             = 1'b0;
      bus.invalidate_all    = 1'b0;
      bus.mem_rd_beat_valid = 1'b0;
      bus.mem_wr_done       = 1'b0;
      check_eq("req_completed", 64'(stop), 64'd1);
   endtask

   // Load: a miss costs 1 + 1 (handshake) + 8 beats + 1 = 11 cycles, a hit 1
   task automatic load_chk(input string tag, input logic [63:0] addr, input logic [63:0] base,
                           input logic [63:0] exp_rdata, input int exp_nrd);
      run_req(addr, 1'b0, 64'd0, 2'd3, base, 1'b0, -1);
      check_eq({tag, "_rdata"}, t_rdata, exp_rdata);
      check_eq({tag, "_nrd"}, 64'(t_nrd), 64'(exp_nrd));
      check_eq({tag, "_latency"}, 64'(t_cycles), (exp_nrd != 0) ? 64'd11 : 64'd1);
      if (exp_nrd != 0) check_eq({tag, "_rd_addr"}, t_rd_addr, {addr[63:6], 6'b0});
      idle(1, 1'b0);
   endtask

   // Store: LOOKUP, WR_REQ (granted), WR_WAIT with done -> pulse at k=3
   task automatic store_chk(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [1:0] wlen, input logic [63:0] exp_addr,
                            input logic [63:0] exp_data, input logic [7:0] exp_strb);
      run_req(addr, 1'b1, wdata, wlen, 64'd0, 1'b0, -1);
      check_eq({tag, "_nwr"}, 64'(t_nwr), 64'd1);
      check_eq({tag, "_nrd"}, 64'(t_nrd), 64'd0);
      check_eq({tag, "_wr_addr"}, t_wr_addr, exp_addr);
      check_eq({tag, "_wr_data"}, t_wr_data, exp_data);
      check_eq({tag, "_wr_strb"}, 64'(t_wr_strb), 64'(exp_strb));
      check_eq({tag, "_latency"}, 64'(t_cycles), 64'd3);
      idle(1, 1'b0);
   endtask

   initial begin
      reset                 = 1'b1;
      bus.invalidate_all    = 1'b0;
      bus.dc_en             = 1'b0;
      bus.dc_in_addr        = '0;
      bus.dc_write_en       = 1'b0;
      bus.dc_in_wdata       = '0;
      bus.dc_in_wlen        = '0;
      bus.mem_rd_ready      = 1'b1;
      bus.mem_rd_beat_valid = 1'b0;
      bus.mem_rd_beat       = '0;
      bus.mem_wr_ready      = 1'b1;
      bus.mem_wr_done       = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check_eq("rst_rvalid",     64'(bus.dc_out_rvalid), 64'd0);
      check_eq("rst_write_done", 64'(bus.dc_out_write_done), 64'd0);
      check_eq("rst_rd_valid",   64'(bus.mem_rd_valid), 64'd0);
      check_eq("rst_wr_valid",   64'(bus.mem_wr_valid), 64'd0);
      check_eq("rst_wr_strb",    64'(bus.mem_wr_strb), 64'd0);

      // Cold miss then warm hit
      load_chk("cold", 64'h1008, 64'h10, 64'h11, 1);
      load_chk("warm", 64'h1008, 64'h10, 64'h11, 0);

      // Store byte hit merges into line
      store_chk("st_byte", 64'h100D, 64'hAB, 2'd0, 64'h1008, 64'h0000_AB00_0000_0000, 8'h20);
      load_chk("st_merge", 64'h1008, 64'h10, 64'h0000_AB00_0000_0011, 0);

      // Store miss: write only, no allocate
      store_chk("st_miss", 64'h2000, 64'h1122_3344_5566_7788, 2'd3, 64'h2000,
                64'h1122_3344_5566_7788, 8'hFF);
      load_chk("after_st_miss", 64'h2000, 64'h20, 64'h20, 1);

      // Conflict in set 0
      load_chk("conf_a",       64'h1000, 64'h10, 64'h10, 1);
      load_chk("conf_b",       64'h1000 + 64'(SETS) * 64, 64'h20, 64'h20, 1);
      load_chk("conf_a_again", 64'h1000, 64'h10, 64'h10, 1);

      // Invalidate in IDLE
      load_chk("pre_inv_hit", 64'h1000, 64'h10, 64'h10, 0);
      idle(1, 1'b1);
      load_chk("post_inv", 64'h1000, 64'h10, 64'h10, 1);

      // Invalidate held across a whole refill is not honoured there
      load_chk("fill_set2", 64'h1080, 64'h50, 64'h50, 1);
      run_req(64'h3040, 1'b0, 64'd0, 2'd3, 64'h30, 1'b1, -1);
      check_eq("inv_refill_rdata",   t_rdata, 64'h30);
      check_eq("inv_refill_nrd",     64'(t_nrd), 64'd1);
      check_eq("inv_refill_latency", 64'(t_cycles), 64'd11);
      idle(1, 1'b0);
      load_chk("set2_survives",   64'h1080, 64'h50, 64'h50, 0);
      load_chk("inv_refill_line", 64'h3040, 64'h30, 64'h30, 0);

      // Halfword store hit
      store_chk("st_half", 64'h3046, 64'hBEEF, 2'd1, 64'h3040, 64'hBEEF_0000_0000_0000, 8'hC0);
      load_chk("half_merge", 64'h3040, 64'h30, 64'hBEEF_0000_0000_0030, 0);

      // dc_en dropped at beat 3: no pulse, line still installed
      run_req(64'h40C0, 1'b0, 64'd0, 2'd3, 64'h40, 1'b0, 3);
      check_eq("drop_pulses", 64'(t_npulse), 64'd0);
      check_eq("drop_nrd",    64'(t_nrd), 64'd1);
      idle(1, 1'b0);
      load_chk("drop_installed", 64'h40F8, 64'h40, 64'h47, 0);

      // Reset in WR_WAIT
      bus.dc_in_addr  = 64'h1000;
      bus.dc_write_en = 1'b1;
      bus.dc_in_wdata = 64'h55;
      bus.dc_in_wlen  = 2'd0;
      bus.dc_en       = 1'b1;
      tick();
      tick();
      check_eq("rstw_wr_req", 64'(bus.mem_wr_valid), 64'd1);
      tick();
      reset     = 1'b1;
      bus.dc_en = 1'b0;
      tick();
      check_eq("rstw_wr_valid",   64'(bus.mem_wr_valid), 64'd0);
      check_eq("rstw_write_done", 64'(bus.dc_out_write_done), 64'd0);
      check_eq("rstw_rd_valid",   64'(bus.mem_rd_valid), 64'd0);
      check_eq("rstw_rvalid",     64'(bus.dc_out_rvalid), 64'd0);
      check_eq("rstw_wr_strb",    64'(bus.mem_wr_strb), 64'd0);
      check_eq("rstw_wr_data",    bus.mem_wr_data, 64'd0);
      reset = 1'b0;
      bus.mem_wr_done = 1'b1;
      tick();
      check_eq("rstw_late_done", 64'(bus.dc_out_write_done), 64'd0);
      bus.mem_wr_done = 1'b0;
      tick();
      load_chk("post_reset_miss", 64'h40F8, 64'h40, 64'h47, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
